// File: rtl/axi4l_multi_uart_bridge.sv
// AXI4-Lite slave fronting NUM_CH UART TX/RX FIFO pairs, 8 bytes per channel from BASE_ADDR.
// Define AXI_UART_BRIDGE_STATUS_EN to add a read-only status word just past the channel window.
module axi4l_multi_uart_bridge #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                NUM_CH    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       ACLK,
    input  logic                       ARSTn,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic [2:0]                 AWPROT,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [DATA_W/8-1:0]        WSTRB,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic [2:0]                 ARPROT,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic [NUM_CH-1:0]          tx_push,
    output logic [DATA_W-1:0]          tx_data,
    output logic [DATA_W/8-1:0]        tx_strb,
    input  logic [NUM_CH-1:0]          tx_full,
    output logic [NUM_CH-1:0]          rx_pop,
    input  logic [NUM_CH*DATA_W-1:0]   rx_data,
    input  logic [NUM_CH-1:0]          rx_empty
);

    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] WIN         = ADDR_W'(8 * NUM_CH);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_e;

    typedef struct packed {
        logic       hit;
        logic       sel;
        logic [3:0] ch;
    } dec_t;

    // hit covers the channel window only; sel = 0 is the TX word, 1 the RX word.
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        dec_t              d;
        off   = addr - BASE_ADDR;
        d.hit = (addr >= BASE_ADDR) && (off < WIN);
        d.sel = off[2];
        d.ch  = off[6:3];
        return d;
    endfunction

    w_state_e                w_state_q;
    r_state_e                r_state_q;
    logic                    aw_got_q, w_got_q;
    logic                    awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [ADDR_W-1:0]       awaddr_q, araddr_q;
    logic [DATA_W-1:0]       wdata_q, rdata_q, rdata_d;
    logic [DATA_W/8-1:0]     wstrb_q;
    logic                    aw_hs, w_hs, aw_seen, w_seen;
    dec_t                    w_dec, r_dec;
    logic [NUM_CH-1:0]       w_sel, r_sel;
    logic                    w_ok, r_ok, r_resp_ok;
    logic [DATA_W-1:0]       r_word;
    logic                    unused_prot;

    assign unused_prot = ^{AWPROT, ARPROT};

    assign aw_hs   = AWVALID & awready_q;
    assign w_hs    = WVALID & wready_q;
    assign aw_seen = aw_got_q | aw_hs;
    assign w_seen  = w_got_q | w_hs;

    assign w_dec = decode(awaddr_q);
    assign r_dec = decode(araddr_q);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
        assign w_sel[gi] = (w_dec.ch == 4'(gi));
        assign r_sel[gi] = (r_dec.ch == 4'(gi));
    end

    assign w_ok = w_dec.hit & ~w_dec.sel & ~|(w_sel & tx_full);
    assign r_ok = r_dec.hit &  r_dec.sel & ~|(r_sel & rx_empty);

    // Strobes come straight from the EXEC state so an async reset kills them at once.
    assign tx_push = ((w_state_q == W_EXEC) && w_ok) ? w_sel : '0;
    assign rx_pop  = ((r_state_q == R_EXEC) && r_ok) ? r_sel : '0;
    assign tx_data = wdata_q;
    assign tx_strb = wstrb_q;

    always_comb begin
        r_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_sel[c]) r_word = rx_data[c*DATA_W +: DATA_W];
        end
    end

`ifdef AXI_UART_BRIDGE_STATUS_EN
    logic              r_stat;
    logic [DATA_W-1:0] stat_word;
    logic [ADDR_W-1:0] r_off;

    assign r_off  = araddr_q - BASE_ADDR;
    assign r_stat = (araddr_q >= BASE_ADDR) && (r_off[ADDR_W-1:2] == WIN[ADDR_W-1:2]);

    always_comb begin
        stat_word               = '0;
        stat_word[NUM_CH-1:0]   = tx_full;
        stat_word[16 +: NUM_CH] = rx_empty;
    end

    assign r_resp_ok = r_ok | r_stat;
    assign rdata_d   = r_ok ? r_word : (r_stat ? stat_word : '0);
`else
    assign r_resp_ok = r_ok;
    assign rdata_d   = r_ok ? r_word : '0;
`endif

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) awaddr_q <= AWADDR;
                    if (w_hs) begin
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                    end
                    if (aw_seen && w_seen) begin
                        w_state_q <= W_EXEC;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else begin
                        aw_got_q  <= aw_seen;
                        w_got_q   <= w_seen;
                        awready_q <= ~aw_seen;
                        wready_q  <= ~w_seen;
                    end
                end
                W_EXEC: begin
                    bresp_q   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_q  <= 1'b1;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            araddr_q  <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ARVALID && arready_q) begin
                        araddr_q  <= ARADDR;
                        arready_q <= 1'b0;
                        r_state_q <= R_EXEC;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_EXEC: begin
                    rdata_q   <= rdata_d;
                    rresp_q   <= r_resp_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4l_multi_uart_bridge.sv
// Randomised scoreboard bench for axi4l_multi_uart_bridge: drivers queue expected responses from an
// address-arithmetic model, a negedge monitor pops and compares whatever the DUT presents.
module tb_axi4l_multi_uart_bridge;

    localparam int          NCH  = 4;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h40;
    localparam int          TMO  = 200;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic              ACLK, ARSTn;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0]     AWADDR, ARADDR;
    logic [2:0]        AWPROT, ARPROT;
    logic [DW-1:0]     WDATA, RDATA, tx_data;
    logic [DW/8-1:0]   WSTRB, tx_strb;
    logic [1:0]        BRESP, RRESP;
    logic [NCH-1:0]    tx_push, tx_full, rx_pop, rx_empty;
    logic [NCH*DW-1:0] rx_data;

    logic [DW-1:0]     rxw [NCH];

    typedef struct {
        logic [NCH-1:0]  push;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
    } push_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_t;

    push_t          exp_push[$];
    logic [1:0]     exp_b[$];
    logic [NCH-1:0] exp_pop[$];
    rd_t            exp_r[$];

    int tests  = 0;
    int failed = 0;

    axi4l_multi_uart_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARSTn(ARSTn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .tx_push(tx_push), .tx_data(tx_data), .tx_strb(tx_strb), .tx_full(tx_full),
        .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string what);
        tests++;
        failed++;
        $display("FAIL timeout_%s actual=no-handshake required=handshake", what);
    endtask

    // Address map: each channel owns 8 bytes; low word = TX, high word = RX; ADDR[1:0] ignored.
    function automatic void wr_model(input logic [31:0] a, input logic [NCH-1:0] full,
                                     output logic [NCH-1:0] push, output logic [1:0] resp);
        longint off;
        int     ch;
        off  = longint'(a) - longint'(BASE);
        push = '0;
        resp = SLVERR;
        if (off >= 0 && off < 8 * NCH) begin
            ch = int'(off / 8);
            if ((off % 8) < 4 && !full[ch]) begin
                push[ch] = 1'b1;
                resp     = OKAY;
            end
        end
    endfunction

    function automatic void rd_model(input logic [31:0] a, input logic [NCH-1:0] empty,
                                     input logic [NCH-1:0] full,
                                     output logic [NCH-1:0] pop, output logic [DW-1:0] data,
                                     output logic [1:0] resp);
        longint off;
        int     ch;
        off  = longint'(a) - longint'(BASE);
        pop  = '0;
        data = '0;
        resp = SLVERR;
        if (off >= 0 && off < 8 * NCH) begin
            ch = int'(off / 8);
            if ((off % 8) >= 4 && !empty[ch]) begin
                pop[ch] = 1'b1;
                data    = rxw[ch];
                resp    = OKAY;
            end
        end
`ifdef AXI_UART_BRIDGE_STATUS_EN
        else if (off >= 8 * NCH && off < 8 * NCH + 4) begin
            data = (DW'(empty) << 16) | DW'(full);
            resp = OKAY;
        end
`endif
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                            input logic [NCH-1:0] full, input int daw, input int dw, input int db);
        logic [NCH-1:0] ep;
        logic [1:0]     er;
        push_t          pe;
        tx_full = full;
        wr_model(a, full, ep, er);
        if (ep != '0) begin
            pe.push = ep;
            pe.data = d;
            pe.strb = s;
            exp_push.push_back(pe);
        end
        exp_b.push_back(er);
        $display("[TB] WR addr=%h data=%h strb=%h full=%b exp_push=%b exp_resp=%0d", a, d, s, full, ep, er);
        fork
            begin
                int n = 0;
                repeat (daw) @(posedge ACLK);
                #1 AWVALID = 1'b1; AWADDR = a;
                @(negedge ACLK);
                while (!AWREADY && n < TMO) begin @(negedge ACLK); n++; end
                if (n >= TMO) timeout("awready");
                @(posedge ACLK); #1 AWVALID = 1'b0;
            end
            begin
                int n = 0;
                repeat (dw) @(posedge ACLK);
                #1 WVALID = 1'b1; WDATA = d; WSTRB = s;
                @(negedge ACLK);
                while (!WREADY && n < TMO) begin @(negedge ACLK); n++; end
                if (n >= TMO) timeout("wready");
                @(posedge ACLK); #1 WVALID = 1'b0;
            end
            begin
                int n = 0;
                @(negedge ACLK);
                while (!BVALID && n < TMO) begin @(negedge ACLK); n++; end
                if (n >= TMO) timeout("bvalid");
                @(posedge ACLK);
                repeat (db) @(posedge ACLK);
                #1 BREADY = 1'b1;
                @(posedge ACLK); #1 BREADY = 1'b0;
            end
        join
    endtask

    task automatic do_read(input logic [31:0] a, input logic [NCH-1:0] empty, input int dr);
        logic [NCH-1:0] ep;
        rd_t            re;
        rx_empty = empty;
        for (int c = 0; c < NCH; c++) rx_data[c*DW +: DW] = rxw[c];
        rd_model(a, empty, tx_full, ep, re.data, re.resp);
        if (ep != '0) exp_pop.push_back(ep);
        exp_r.push_back(re);
        $display("[TB] RD addr=%h empty=%b exp_pop=%b exp_data=%h exp_resp=%0d", a, empty, ep, re.data, re.resp);
        begin
            int n = 0;
            #1 ARVALID = 1'b1; ARADDR = a;
            @(negedge ACLK);
            while (!ARREADY && n < TMO) begin @(negedge ACLK); n++; end
            if (n >= TMO) timeout("arready");
            @(posedge ACLK); #1 ARVALID = 1'b0;
            n = 0;
            @(negedge ACLK);
            while (!RVALID && n < TMO) begin @(negedge ACLK); n++; end
            if (n >= TMO) timeout("rvalid");
            @(posedge ACLK);
            repeat (dr) @(posedge ACLK);
            #1 RREADY = 1'b1;
            @(posedge ACLK); #1 RREADY = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_addr(input int kind, input int ch);
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case (kind)
            0:       return BASE + 32'(8 * ch) + lo;
            1:       return BASE + 32'(8 * ch) + 32'd4 + lo;
            2:       return BASE - 32'(4 * $urandom_range(1, 16));
            3:       return BASE + 32'(8 * NCH) + 32'd8 + 32'($urandom_range(0, 64));
            default: return BASE + 32'(8 * NCH) + lo;
        endcase
    endfunction

    // Monitor: every DUT-presented event is matched against the scoreboard queues.
    logic           prev_bv, prev_br, prev_rv, prev_rr;
    logic [1:0]     prev_bresp, prev_rresp;
    logic [DW-1:0]  prev_rdata;

    always @(negedge ACLK) begin : mon
        push_t pe;
        rd_t   re;
        if (tx_push != '0) begin
            if (exp_push.size() == 0) chk("unexpected_push", 64'(tx_push), 64'd0);
            else begin
                pe = exp_push.pop_front();
                chk("tx_push", 64'(tx_push), 64'(pe.push));
                chk("tx_data", 64'(tx_data), 64'(pe.data));
                chk("tx_strb", 64'(tx_strb), 64'(pe.strb));
            end
        end
        if (rx_pop != '0) begin
            if (exp_pop.size() == 0) chk("unexpected_pop", 64'(rx_pop), 64'd0);
            else chk("rx_pop", 64'(rx_pop), 64'(exp_pop.pop_front()));
        end
        if (BVALID && BREADY) begin
            if (exp_b.size() == 0) chk("unexpected_b", 64'(BVALID), 64'd0);
            else begin
                chk("bresp", 64'(BRESP), 64'(exp_b.pop_front()));
                chk("push_before_b", 64'(exp_push.size()), 64'd0);
            end
        end
        if (RVALID && RREADY) begin
            if (exp_r.size() == 0) chk("unexpected_r", 64'(RVALID), 64'd0);
            else begin
                re = exp_r.pop_front();
                chk("rdata", 64'(RDATA), 64'(re.data));
                chk("rresp", 64'(RRESP), 64'(re.resp));
                chk("pop_before_r", 64'(exp_pop.size()), 64'd0);
            end
        end
        if (ARSTn && prev_bv && !prev_br) begin
            chk("bvalid_hold", 64'(BVALID), 64'd1);
            chk("bresp_hold", 64'(BRESP), 64'(prev_bresp));
        end
        if (ARSTn && prev_rv && !prev_rr) begin
            chk("rvalid_hold", 64'(RVALID), 64'd1);
            chk("rdata_hold", 64'(RDATA), 64'(prev_rdata));
            chk("rresp_hold", 64'(RRESP), 64'(prev_rresp));
        end
        prev_bv    = ARSTn & BVALID;
        prev_br    = BREADY;
        prev_bresp = BRESP;
        prev_rv    = ARSTn & RVALID;
        prev_rr    = RREADY;
        prev_rdata = RDATA;
        prev_rresp = RRESP;
    end

    initial begin
        ARSTn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = '0; RREADY = 1'b0;
        tx_full = '0; rx_empty = '1; rx_data = '0;
        for (int c = 0; c < NCH; c++) rxw[c] = '0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'(OKAY));
        chk("rst_rresp", 64'(RRESP), 64'(OKAY));
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_tx_strb", 64'(tx_strb), 64'd0);
        @(posedge ACLK); #1 ARSTn = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rel_awready", 64'(AWREADY), 64'd1);
        chk("rel_wready", 64'(WREADY), 64'd1);
        chk("rel_arready", 64'(ARREADY), 64'd1);

        // Reset lands in the cycle after the AW/W handshake: the push must never appear.
        @(posedge ACLK);
        #1 AWVALID = 1'b1; AWADDR = BASE + 32'h18; WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        @(posedge ACLK);
        #1 AWVALID = 1'b0; WVALID = 1'b0; ARSTn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARSTn = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("mid_rst_awready", 64'(AWREADY), 64'd1);
        chk("mid_rst_wready", 64'(WREADY), 64'd1);
        chk("mid_rst_arready", 64'(ARREADY), 64'd1);
        chk("mid_rst_bvalid", 64'(BVALID), 64'd0);
        chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
        @(posedge ACLK); #1;

        do_write(BASE + 32'h18, 32'h0000_00A5, 4'hF, 4'b0000, 0, 0, 0);
        do_write(BASE + 32'h08, 32'h1234_5678, 4'h3, 4'b0000, 3, 0, 1);
        do_write(BASE + 32'h08, 32'h0BAD_0BAD, 4'hF, 4'b0010, 0, 0, 0);
        rxw[2] = 32'h0000_005A;
        do_read(BASE + 32'h14, 4'b0000, 0);
        do_read(BASE + 32'h14, 4'b1111, 0);
        do_read(BASE + 32'h10, 4'b0000, 1);
        do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 4'b0000, 0, 1, 0);
        do_write(BASE - 32'h8, 32'h1111_1111, 4'hF, 4'b0000, 0, 0, 0);
        rxw[1] = 32'hC0FF_EE01;
        fork
            do_read(BASE + 32'h0C, 4'b0000, 5);
            do_write(BASE + 32'h00, 32'h0000_0077, 4'h1, 4'b0000, 0, 0, 0);
        join
`ifdef AXI_UART_BRIDGE_STATUS_EN
        tx_full = 4'b0010;
        do_read(BASE + 32'h20, 4'b1100, 0);
        do_write(BASE + 32'h20, 32'h5555_5555, 4'hF, 4'b0000, 0, 0, 0);
`endif

        fork
            for (int i = 0; i < 120; i++) begin
                int k;
                int kind;
                k    = int'($urandom_range(0, 9));
                kind = (k <= 4) ? 0 : (k <= 6) ? 1 : (k == 7) ? 2 : (k == 8) ? 3 : 4;
                do_write(pick_addr(kind, int'($urandom_range(0, NCH - 1))), $urandom,
                         4'($urandom_range(0, 15)), NCH'($urandom & $urandom),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
            end
            for (int i = 0; i < 120; i++) begin
                int k;
                int kind;
                k    = int'($urandom_range(0, 9));
                kind = (k <= 4) ? 1 : (k <= 6) ? 0 : (k == 7) ? 2 : 3;
`ifndef AXI_UART_BRIDGE_STATUS_EN
                if (k == 9) kind = 4;
`endif
                for (int c = 0; c < NCH; c++) rxw[c] = $urandom;
                do_read(pick_addr(kind, int'($urandom_range(0, NCH - 1))), NCH'($urandom & $urandom),
                        int'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 2)) @(posedge ACLK);
            end
        join

        repeat (5) @(posedge ACLK);
        @(negedge ACLK);
        chk("left_push", 64'(exp_push.size()), 64'd0);
        chk("left_pop", 64'(exp_pop.size()), 64'd0);
        chk("left_b", 64'(exp_b.size()), 64'd0);
        chk("left_r", 64'(exp_r.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
